// File: rtl/pin_mux_seq.sv
// Registered N-channel pin multiplexer with handshaked, blanked channel switching.
// Optional multi-hot request rejection: define PIN_MUX_SEL_CHECK_EN.
module pin_mux_seq #(
  parameter int CHANNELS = 3,
  parameter int IN_W     = 19,
  parameter int OUT_W    = 8,
  parameter int GAP      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       sel_req,
  input  logic                      sel_valid,
  output logic                      sel_ready,
  input  logic [CHANNELS*IN_W-1:0]  ch_in,
  input  logic [CHANNELS*OUT_W-1:0] ch_out,
  output logic [IN_W-1:0]           bus_in,
  output logic [OUT_W-1:0]          bus_out,
  output logic [CHANNELS-1:0]       active,
  output logic                      sel_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_BLANK  = 2'd2;

  localparam logic [7:0]          CNT_LOAD = 8'(GAP - 1);
  localparam logic [CHANNELS-1:0] ONE      = CHANNELS'(1);

  logic [1:0]          state_q, state_d;
  logic [CHANNELS-1:0] active_q, active_d;
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [IN_W-1:0]     bus_in_q, bus_in_d;
  logic [OUT_W-1:0]    bus_out_q, bus_out_d;

  logic                accept;
  logic                reject;
  logic [CHANNELS-1:0] req_eff;

  assign sel_ready = (state_q != ST_BLANK);
  assign accept    = sel_valid && sel_ready;

`ifdef PIN_MUX_SEL_CHECK_EN
  assign req_eff = sel_req;
  assign reject  = accept && ((sel_req & (sel_req - ONE)) != '0);
`else
  // Multi-hot requests collapse to their lowest set bit.
  assign req_eff = sel_req & (~sel_req + ONE);
  assign reject  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    err_d     = reject;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == 8'd0) begin
          active_d = pending_q;
          state_d  = (pending_q != '0) ? ST_ACTIVE : ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        if (accept && !reject && (req_eff != active_q)) begin
          state_d   = ST_BLANK;
          pending_d = req_eff;
          active_d  = '0;
          cnt_d     = CNT_LOAD;
        end
      end
    endcase
  end

  // Route from the next-cycle selection so the bus never lags the active flags.
  always_comb begin
    bus_in_d  = '0;
    bus_out_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bus_in_d  = bus_in_d  | (ch_in[i*IN_W +: IN_W]   & {IN_W{active_d[i]}});
      bus_out_d = bus_out_d | (ch_out[i*OUT_W +: OUT_W] & {OUT_W{active_d[i]}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      active_q  <= '0;
      pending_q <= '0;
      cnt_q     <= 8'd0;
      err_q     <= 1'b0;
      bus_in_q  <= '0;
      bus_out_q <= '0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      bus_in_q  <= bus_in_d;
      bus_out_q <= bus_out_d;
    end
  end

  assign bus_in  = bus_in_q;
  assign bus_out = bus_out_q;
  assign active  = active_q;
  assign sel_err = err_q;

endmodule

// File: tb/tb_pin_mux_seq.sv
// Self-checking bench for pin_mux_seq against an edge-indexed behavioural model.
// Honours PIN_MUX_SEL_CHECK_EN the same way as the design.
module tb_pin_mux_seq;

  localparam int CH  = 3;
  localparam int IW  = 19;
  localparam int OW  = 8;
  localparam int GAP = 4;

  logic              clk;
  logic              rst_n;
  logic [CH-1:0]     sel_req;
  logic              sel_valid;
  logic              sel_ready;
  logic [CH*IW-1:0]  ch_in;
  logic [CH*OW-1:0]  ch_out;
  logic [IW-1:0]     bus_in;
  logic [OW-1:0]     bus_out;
  logic [CH-1:0]     active;
  logic              sel_err;

  int vectors;
  int miscompares;

  // Model: a switch is a scheduled event at an absolute edge number.
  int            edge_no;
  bit            m_blank;
  int            m_switch_edge;
  logic [CH-1:0] m_active;
  logic [CH-1:0] m_pending;
  logic          exp_err;

  pin_mux_seq #(.CHANNELS(CH), .IN_W(IW), .OUT_W(OW), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .sel_req(sel_req), .sel_valid(sel_valid),
    .sel_ready(sel_ready), .ch_in(ch_in), .ch_out(ch_out), .bus_in(bus_in),
    .bus_out(bus_out), .active(active), .sel_err(sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [31:0] obs = {bus_in, bus_out, active, sel_ready, sel_err};

  function automatic logic [31:0] exp_vec();
    logic [IW-1:0] bi;
    logic [OW-1:0] bo;
    bi = '0;
    bo = '0;
    for (int k = 0; k < CH; k++)
      if (m_active == CH'(1 << k)) begin
        bi = ch_in[k*IW +: IW];
        bo = ch_out[k*OW +: OW];
      end
    return {bi, bo, m_active, !m_blank, exp_err};
  endfunction

  task automatic model_reset();
    m_blank  = 0;
    m_active = '0;
    m_pending = '0;
    exp_err  = 1'b0;
  endtask

  task automatic model_edge();
    logic [CH-1:0] req;
    int n;
    exp_err = 1'b0;
    if (m_blank) begin
      if (edge_no == m_switch_edge) begin
        m_active = m_pending;
        m_blank  = 0;
      end
    end else if (sel_valid) begin
      req = sel_req;
      n   = $countones(sel_req);
`ifdef PIN_MUX_SEL_CHECK_EN
      if (n > 1) exp_err = 1'b1;
`else
      if (n > 1) begin
        for (int k = CH - 1; k >= 0; k--)
          if (sel_req[k]) req = CH'(1 << k);
      end
`endif
      if (!exp_err && req != m_active) begin
        m_blank       = 1;
        m_pending     = req;
        m_active      = '0;
        m_switch_edge = edge_no + GAP;
      end
    end
    edge_no++;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sel_valid = 1'b0;
    sel_req = '0;
    #1;
    model_reset();
    vectors++;
    if (obs !== 32'h0000_0002) begin
      miscompares++;
      $display("[TB] FAIL reset_values: got %h expected %h", obs, 32'h0000_0002);
    end
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    tick();
    vectors++;
    if (obs !== exp_vec()) begin
      miscompares++;
      $display("[TB] FAIL reset_idle: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_first_switch();
    sel_req = 3'b001;
    sel_valid = 1'b1;
    for (int i = 0; i <= GAP; i++) begin
      tick();
      sel_valid = 1'b0;
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL first_switch_e%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    vectors++;
    if (bus_in !== 19'd42 || bus_out !== 8'd43 || active !== 3'b001) begin
      miscompares++;
      $display("[TB] FAIL first_switch_dest: got %0d/%0d/%b expected 42/43/001", bus_in, bus_out, active);
    end
  endtask

  task automatic test_data_follow();
    ch_in[IW-1:0] = 19'd7;
    tick();
    vectors++;
    if (bus_in !== 19'd7 || obs !== exp_vec()) begin
      miscompares++;
      $display("[TB] FAIL data_follow: got %0d expected 7", bus_in);
    end
    ch_in[IW-1:0] = 19'd42;
    tick();
  endtask

  task automatic test_switch_and_rerequest();
    sel_req = 3'b100;
    sel_valid = 1'b1;
    for (int i = 0; i <= GAP; i++) begin
      tick();
      sel_valid = 1'b0;
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL switch_100_e%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    vectors++;
    if (bus_in !== 19'd3 || bus_out !== 8'd13) begin
      miscompares++;
      $display("[TB] FAIL switch_100_dest: got %0d/%0d expected 3/13", bus_in, bus_out);
    end
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    vectors++;
    if (obs !== exp_vec() || sel_ready !== 1'b1 || bus_in !== 19'd3) begin
      miscompares++;
      $display("[TB] FAIL rerequest_noop: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_multihot();
    sel_req = 3'b110;
    sel_valid = 1'b1;
    for (int i = 0; i <= GAP + 1; i++) begin
      tick();
      sel_valid = 1'b0;
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL multihot_e%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
`ifdef PIN_MUX_SEL_CHECK_EN
    vectors++;
    if (active !== 3'b100 || bus_in !== 19'd3) begin
      miscompares++;
      $display("[TB] FAIL multihot_reject: got %b/%0d expected 100/3", active, bus_in);
    end
`else
    vectors++;
    if (active !== 3'b010 || bus_in !== 19'd2) begin
      miscompares++;
      $display("[TB] FAIL multihot_lowest: got %b/%0d expected 010/2", active, bus_in);
    end
`endif
  endtask

  task automatic test_reset_mid_blank();
    sel_req = (m_active == 3'b001) ? 3'b010 : 3'b001;
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (obs !== 32'h0000_0002) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_blank: got %h expected %h", obs, 32'h0000_0002);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < GAP + 1; i++) tick();
    vectors++;
    if (obs !== exp_vec() || active !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_drop_pending: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_deselect();
    sel_req = 3'b010;
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    for (int i = 0; i < GAP; i++) tick();
    sel_req = 3'b000;
    sel_valid = 1'b1;
    for (int i = 0; i <= GAP; i++) begin
      tick();
      sel_valid = 1'b0;
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL deselect_e%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    vectors++;
    if (active !== 3'b000 || bus_in !== 19'd0 || sel_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL deselect_idle: got %b/%0d/%b expected 000/0/1", active, bus_in, sel_ready);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      sel_valid = ($urandom_range(0, 2) == 0);
      sel_req   = CH'($urandom_range(0, 7));
      ch_in     = {IW'($urandom), IW'($urandom), IW'($urandom)};
      ch_out    = {OW'($urandom), OW'($urandom), OW'($urandom)};
      tick();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL random_%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    edge_no = 0;
    m_switch_edge = 0;
    model_reset();
    ch_in  = {19'd3, 19'd2, 19'd42};
    ch_out = {8'd13, 8'd12, 8'd43};
    test_reset();
    test_first_switch();
    test_data_follow();
    test_switch_and_rerequest();
    test_multihot();
    test_reset_mid_blank();
    test_deselect();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pin_mux_seq.md
# pin_mux_seq

Parametrised, registered N-channel pin multiplexer with handshaked, glitch-free channel switching. Each channel presents an IN_W-bit input-pin image and an OUT_W-bit output-pin image; exactly one channel, or none, is routed to the shared pin bus. Every channel change passes through a blanking interval during which the shared bus is driven to zero. The block sits between the per-design cores and the chip I/O ring.

## Interface
- CHANNELS, 3, number of selectable channels (2..16)
- IN_W, 19, input-pin image width per channel
- OUT_W, 8, output-pin image width per channel
- GAP, 4, blanking cycles on a channel change (1..255)

- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- sel_req  in  CHANNELS  requested channel, one-hot; all-zero means deselect
- sel_valid  in  1  request valid
- sel_ready  out  1  request can be accepted; low only in BLANK
- ch_in  in  CHANNELS*IN_W  channel input images; channel i at [i*IN_W +: IN_W]
- ch_out  in  CHANNELS*OUT_W  channel output images; channel i at [i*OUT_W +: OUT_W]
- bus_in  out  IN_W  routed input image, registered
- bus_out  out  OUT_W  routed output image, registered
- active  out  CHANNELS  currently routed channel, one-hot, or 0
- sel_err  out  1  one-cycle pulse flagging a rejected request

## Operation
- States: IDLE (active = 0), ACTIVE (active is one-hot), BLANK (active = 0, switch pending).
- Accept: sel_valid && sel_ready at a rising edge.
- Accepted sel_req equal to current active: no-op; state, bus and active unchanged.
- Accepted sel_req different from current active: enter BLANK, latch sel_req as pending, load counter with GAP-1.
- BLANK: counter decrements each cycle; when it reaches 0, the next edge moves to ACTIVE with active = pending, or to IDLE if pending == 0.
- Routing: bus_in = OR over i of (ch_in[i] & {IN_W{active_next[i]}}), registered. bus_out follows the same rule with ch_out. Result is zero when active_next == 0.
- sel_valid while sel_ready is low: ignored and not queued; the requester must hold it.
- Multi-hot sel_req: behaviour depends on SEL_CHECK (see Configuration).
- Reset asserted mid-BLANK: pending request is dropped and the block returns to IDLE.

## Timing
- Reset values: bus_in = 0, bus_out = 0, active = 0, sel_err = 0, state IDLE, sel_ready = 1.
- Data latency: in ACTIVE, the bus after edge n equals the routed channel data sampled at edge n, i.e. 1 cycle.
- Switch, with accept at edge 0:
  - After edges 0..GAP-1: bus = 0, active = 0, sel_ready = 0.
  - After edge GAP: active = pending, bus carries the new channel's data sampled at edge GAP, sel_ready = 1.
- The old channel's data never appears after the accept edge, and the new channel's data never appears before edge GAP.
- Back-to-back requests: a new request can be accepted at edge GAP+1 at the earliest, because sel_ready is high in the cycle following edge GAP.
- sel_err is high for exactly the one cycle following the rejecting edge.

## Configuration
- PIN_MUX_SEL_CHECK_EN defined:
  - A multi-hot sel_req is still handshaked (sel_ready unaffected) but is rejected.
  - No state change; sel_err pulses for one cycle.
- PIN_MUX_SEL_CHECK_EN undefined:
  - A multi-hot sel_req resolves to its lowest set bit and is processed normally.
  - sel_err is tied to 0.

## Test plan
All scenarios use CHANNELS=3, IN_W=19, OUT_W=8, GAP=4, with ch_in = {19'd3, 19'd2, 19'd42} and ch_out = {8'd13, 8'd12, 8'd43}.
- Reset with sel_valid low -> bus_in = 0, bus_out = 0, active = 0, sel_ready = 1, sel_err = 0.
- From IDLE, sel_req = 3'b001 accepted at edge 0 -> zero bus and sel_ready = 0 for 4 cycles; after edge 4, active = 001, bus_in = 42, bus_out = 43.
- In ACTIVE on channel 0, change ch_in[0] to 19'd7 -> bus_in = 7 one edge later.
- While on 001, request 3'b100 -> 4 zero cycles, then bus_in = 3, bus_out = 13. Re-request 3'b100 -> no blanking, bus unchanged.
- Request 3'b110:
  - With PIN_MUX_SEL_CHECK_EN defined: 1-cycle sel_err, state unchanged.
  - With it undefined: switch to 3'b010 after blanking, bus_in = 2.
- Assert rst_n low at cycle 2 of BLANK -> outputs zero immediately; after release, IDLE and active = 0. Also check sel_req = 0 while ACTIVE -> 4 zero cycles, then IDLE.
